// File: rtl/mul_pkg.sv
// Shared widths for the mul_4 leaf multiplier and its bus interface.
package mul_pkg;
   localparam int unsigned MUL_OP_W   = 4;
   localparam int unsigned MUL_PROD_W = 8;
endpackage

// File: rtl/mul_4_if.sv
// Operand/product bundle for mul_4: operands in, combinational and registered results out.
interface mul_4_if;
   import mul_pkg::*;

   logic [MUL_OP_W-1:0]   a;
   logic [MUL_OP_W-1:0]   b;
   logic [MUL_PROD_W-1:0] s;
   logic [MUL_PROD_W-1:0] s_q;
   logic [MUL_OP_W-1:0]   a_q;
   logic [MUL_OP_W-1:0]   b_q;

   modport master (output a, b, input s, s_q, a_q, b_q);
   modport slave  (input a, b, output s, s_q, a_q, b_q);
endinterface

// File: rtl/fa.sv
// One-bit full adder; used as a half adder by tying cin low.
module fa (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/mul_4.sv
// Unsigned 4x4 array multiplier: AND plane, three ripple rows of full adders,
// combinational product plus a registered product/operand bank.
module mul_4
   import mul_pkg::*;
(
   input  logic     ck,
   input  logic     rst,
   mul_4_if.slave   bus
);
   logic [MUL_OP_W-1:0][MUL_OP_W-1:0] pp;  // pp[i][j] = a[j] & b[i]
   logic [MUL_PROD_W-1:0]             prod;

   always_comb begin
      pp = '0;
      for (int i = 0; i < MUL_OP_W; i++) begin
         pp[i] = bus.a & {MUL_OP_W{bus.b[i]}};
      end
   end

   // Scalar nets per cell keep each carry chain free of self-referencing vectors.
   logic s1_0, s1_1, s1_2, s1_3, c1_0, c1_1, c1_2, c1_3;
   logic s2_0, s2_1, s2_2, s2_3, c2_0, c2_1, c2_2, c2_3;
   logic s3_0, s3_1, s3_2, s3_3, c3_0, c3_1, c3_2, c3_3;

   // Row 1: pp[1] + (pp[0] >> 1)
   fa u_r1c0 (.a(pp[1][0]), .b(pp[0][1]), .cin(1'b0), .sum(s1_0), .cout(c1_0));
   fa u_r1c1 (.a(pp[1][1]), .b(pp[0][2]), .cin(c1_0), .sum(s1_1), .cout(c1_1));
   fa u_r1c2 (.a(pp[1][2]), .b(pp[0][3]), .cin(c1_1), .sum(s1_2), .cout(c1_2));
   fa u_r1c3 (.a(pp[1][3]), .b(1'b0),     .cin(c1_2), .sum(s1_3), .cout(c1_3));

   // Row 2: pp[2] + upper bits of row 1
   fa u_r2c0 (.a(pp[2][0]), .b(s1_1), .cin(1'b0), .sum(s2_0), .cout(c2_0));
   fa u_r2c1 (.a(pp[2][1]), .b(s1_2), .cin(c2_0), .sum(s2_1), .cout(c2_1));
   fa u_r2c2 (.a(pp[2][2]), .b(s1_3), .cin(c2_1), .sum(s2_2), .cout(c2_2));
   fa u_r2c3 (.a(pp[2][3]), .b(c1_3), .cin(c2_2), .sum(s2_3), .cout(c2_3));

   // Row 3: pp[3] + upper bits of row 2; its outputs form s[7:3]
   fa u_r3c0 (.a(pp[3][0]), .b(s2_1), .cin(1'b0), .sum(s3_0), .cout(c3_0));
   fa u_r3c1 (.a(pp[3][1]), .b(s2_2), .cin(c3_0), .sum(s3_1), .cout(c3_1));
   fa u_r3c2 (.a(pp[3][2]), .b(s2_3), .cin(c3_1), .sum(s3_2), .cout(c3_2));
   fa u_r3c3 (.a(pp[3][3]), .b(c2_3), .cin(c3_2), .sum(s3_3), .cout(c3_3));

   assign prod  = {c3_3, s3_3, s3_2, s3_1, s3_0, s2_0, s1_0, pp[0][0]};
   assign bus.s = prod;

   always_ff @(posedge ck) begin
      if (rst) begin
         bus.s_q <= '0;
         bus.a_q <= '0;
         bus.b_q <= '0;
      end else begin
         bus.s_q <= prod;
         bus.a_q <= bus.a;
         bus.b_q <= bus.b;
      end
   end
endmodule

// File: tb/tb_mul_4.sv
// Scoreboard bench for mul_4: driver queues expected results, negedge monitor compares.
module tb_mul_4;
   logic ck = 1'b0;
   logic rst;

   mul_4_if bus ();

   mul_4 dut (
      .ck  (ck),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 ck = ~ck;

   typedef struct packed {
      logic [7:0] s;
      logic [7:0] s_q;
      logic [3:0] a_q;
      logic [3:0] b_q;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // Model of what the last rising edge captured
   logic [3:0] prev_a, prev_b;
   logic [7:0] prev_s;
   logic       prev_rst;

   task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic r,
                        input logic [7:0] s_exp);
      exp_t e;
      @(posedge ck);
      if (prev_rst) begin
         e.s_q = 8'h00;
         e.a_q = 4'h0;
         e.b_q = 4'h0;
      end else begin
         e.s_q = prev_s;
         e.a_q = prev_a;
         e.b_q = prev_b;
      end
      e.s = s_exp;
      #1;
      bus.a    = a;
      bus.b    = b;
      rst      = r;
      prev_a   = a;
      prev_b   = b;
      prev_s   = s_exp;
      prev_rst = r;
      q.push_back(e);
   endtask

   always @(negedge ck) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         cmp("s",   bus.s,          e.s);
         cmp("s_q", bus.s_q,        e.s_q);
         cmp("a_q", {4'h0, bus.a_q}, {4'h0, e.a_q});
         cmp("b_q", {4'h0, bus.b_q}, {4'h0, e.b_q});
      end
   end

   initial begin
      logic [3:0] ra, rb;
      logic       rr;
      bus.a    = 4'h0;
      bus.b    = 4'h0;
      rst      = 1'b1;
      prev_a   = 4'h0;
      prev_b   = 4'h0;
      prev_s   = 8'h00;
      prev_rst = 1'b1;

      // Reset held, then corner products with hand-computed results
      drive(4'h0, 4'h0, 1'b1, 8'h00);
      drive(4'hF, 4'hF, 1'b0, 8'hE1);
      drive(4'h0, 4'hB, 1'b0, 8'h00);
      drive(4'h1, 4'h9, 1'b0, 8'h09);
      drive(4'h8, 4'h8, 1'b0, 8'h40);
      drive(4'h7, 4'h3, 1'b0, 8'h15);
      drive(4'h5, 4'hA, 1'b0, 8'h32);
      drive(4'hC, 4'h6, 1'b0, 8'h48);
      drive(4'h3, 4'hD, 1'b0, 8'h27);
      // Reset mid-stream with full-scale operands: s stays E1, registers clear
      drive(4'hF, 4'hF, 1'b1, 8'hE1);
      drive(4'hF, 4'hF, 1'b0, 8'hE1);
      drive(4'h2, 4'hE, 1'b0, 8'h1C);

      // Exhaustive sweep of {b,a}
      for (int i = 0; i < 256; i++) begin
         ra = i[3:0];
         rb = i[7:4];
         drive(ra, rb, 1'b0, 8'({4'h0, ra} * {4'h0, rb}));
      end

      // Random operands with sparse reset pulses
      for (int i = 0; i < 1000; i++) begin
         ra = 4'($urandom_range(0, 15));
         rb = 4'($urandom_range(0, 15));
         rr = ($urandom_range(0, 15) == 0);
         drive(ra, rb, rr, 8'({4'h0, ra} * {4'h0, rb}));
      end

      @(negedge ck);
      #1;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
